fp_square: RTL and testbench

Sequential IEEE-754 single-precision squaring unit (y = x·x), the inverse of the square-root datapath in the EE3403 floating-point project. It is used to check square-root results and as a standalone operator. A 24-bit mantissa squaring runs as a shift-add loop, one partial product per cycle. A valid/ready handshake sits on both the input and output sides.

---
 rtl/fp_pkg.sv | 43 ++++
 rtl/fp_mant_sq_iter.sv | 67 ++++++
 rtl/fp_square.sv | 160 ++++++++++++++++
 tb/tb_fp_square.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the floating-point project: field widths,
// special encodings, FSM state and operand-class types.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int WORD_W = 32;
    localparam int SIG_W  = MANT_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int BIAS   = 127;

    localparam logic [WORD_W-1:0] QNAN  = 32'h7FC0_0000;
    localparam logic [WORD_W-1:0] PINF  = 32'h7F80_0000;
    localparam logic [WORD_W-1:0] PZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } op_class_e;

    // Denormals classify as ZERO because they are flushed on input.
    function automatic op_class_e classify(input logic [WORD_W-1:0] x);
        op_class_e cls;
        if (x[30:23] == 8'hFF) begin
            cls = (x[22:0] != '0) ? NAN : INF;
        end else if (x[30:23] == 8'h00) begin
            cls = ZERO;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_mant_sq_iter.sv
// Iterative 24x24 shift-add multiplier, one partial product per clock.
// Fed the same significand on both sides here; reusable for a general multiply.
module fp_mant_sq_iter
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SIG_W-1:0]  a,
    output logic              done,
    output logic [PROD_W-1:0] p
);

    localparam logic [4:0] LAST_ITER = 5'd23;

    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [SIG_W-1:0]  mplier_q, mplier_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [4:0]        iter_q, iter_d;
    logic              busy_q, busy_d;

    assign done = busy_q && (iter_q == LAST_ITER);
    assign p    = acc_q;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        iter_d   = iter_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{SIG_W{1'b0}}, a};
            mplier_d = a;
            acc_d    = '0;
            iter_d   = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            // The counter parks at zero after the last step so it never wraps into extra work.
            if (iter_q == LAST_ITER) begin
                iter_d = '0;
                busy_d = 1'b0;
            end else begin
                iter_d = iter_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            iter_q   <= iter_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/fp_square.sv
// Sequential binary32 squaring unit with valid/ready on both sides.
// Define FP_SQUARE_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp_square
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] floating_point_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] result
);

    state_e            state_q, state_d;
    op_class_e         opClass;
    logic              accept;
    logic              mulStart;
    logic              mulDone;
    logic [PROD_W-1:0] product;

    logic [EXP_W-1:0]  opExp_q, opExp_d;
    logic [WORD_W-1:0] pending_q, pending_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic              outValid_q, outValid_d;

    logic              prodTop;
    logic [MANT_W-1:0] mantKept;
    logic [MANT_W-1:0] mantFinal;
    logic signed [9:0] expBase;
    logic signed [9:0] expFinal;
    logic [WORD_W-1:0] normResult;
    logic              unusedBits;

    assign opClass  = classify(floating_point_in);
    assign accept   = (state_q == IDLE) && in_valid;
    assign mulStart = accept && (opClass == NORMAL);

    // The sign is irrelevant to a square, and truncation never looks below the kept field.
    assign unusedBits = floating_point_in[31] ^ (^product[22:0]);

    fp_mant_sq_iter uMantSq (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mulStart),
        .a     ({1'b1, floating_point_in[MANT_W-1:0]}),
        .done  (mulDone),
        .p     (product)
    );

    // Normalisation: a product >= 2.0 sets bit 47 and shifts the kept field up by one.
    always_comb begin
        prodTop  = product[PROD_W-1];
        mantKept = prodTop ? product[46:24] : product[45:23];
        expBase  = $signed({1'b0, opExp_q, 1'b0}) - 10'sd127 + $signed({9'b0, prodTop});
    end

`ifdef FP_SQUARE_RNE_EN
    logic              guardBit;
    logic              stickyBit;
    logic              roundUp;
    logic [MANT_W:0]   mantRounded;

    always_comb begin
        guardBit    = prodTop ? product[23] : product[22];
        stickyBit   = prodTop ? (|product[22:0]) : (|product[21:0]);
        roundUp     = guardBit && (stickyBit || mantKept[0]);
        mantRounded = {1'b0, mantKept} + {{MANT_W{1'b0}}, roundUp};
        mantFinal   = mantRounded[MANT_W-1:0];
        expFinal    = expBase + $signed({9'b0, mantRounded[MANT_W]});
    end
`else
    always_comb begin
        mantFinal = mantKept;
        expFinal  = expBase;
    end
`endif

    always_comb begin
        if (expFinal >= 10'sd255) begin
            normResult = PINF;
        end else if (expFinal <= 10'sd0) begin
            normResult = PZERO;
        end else begin
            normResult = {1'b0, expFinal[EXP_W-1:0], mantFinal};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (opClass == NORMAL) ? MUL : DONE;
            MUL:  if (mulDone) state_d = NORM;
            NORM: state_d = DONE;
            DONE: if (outValid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = outValid_q;
        result    = result_q;
    end

    // DONE spends one cycle moving the pending word into the output register before presenting it.
    always_comb begin
        opExp_d    = opExp_q;
        pending_d  = pending_q;
        result_d   = result_q;
        outValid_d = outValid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opExp_d = floating_point_in[30:23];
                    case (opClass)
                        NAN:     pending_d = QNAN;
                        INF:     pending_d = PINF;
                        ZERO:    pending_d = PZERO;
                        default: pending_d = pending_q;
                    endcase
                end
            end
            NORM: pending_d = normResult;
            DONE: begin
                if (!outValid_q) begin
                    outValid_d = 1'b1;
                    result_d   = pending_q;
                end else if (out_ready) begin
                    outValid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opExp_q    <= '0;
            pending_q  <= '0;
            result_q   <= '0;
            outValid_q <= 1'b0;
        end else begin
            opExp_q    <= opExp_d;
            pending_q  <= pending_d;
            result_q   <= result_d;
            outValid_q <= outValid_d;
        end
    end

endmodule

// File: tb/tb_fp_square.sv
// Scoreboard bench for fp_square: directed spec cases, back-pressure, mid-operation
// reset and randomized operands against an integer-arithmetic reference.
module tb_fp_square;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] floating_point_in = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int transfers = 0;
    bit readyRandom = 1'b0;

    typedef struct {
        logic [31:0] op;
        logic [31:0] expected;
        int          lat;
        int          acceptCyc;
    } txn_t;

    txn_t sbQueue[$];

    fp_square dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .floating_point_in (floating_point_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .result            (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Reference: square the significand as a plain integer and pick the bits by value.
    function automatic logic [31:0] refSquare(input logic [31:0] x);
        int e;
        int sh;
        int re;
        longint unsigned m;
        longint unsigned p;
        longint unsigned kept;
`ifdef FP_SQUARE_RNE_EN
        longint unsigned rem;
        longint unsigned half;
`endif
        e = int'(x[30:23]);
        if (e == 255) return (x[22:0] != 23'h0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        if (e == 0) return 32'h0;
        m  = 64'(x[22:0]) + (64'd1 << 23);
        p  = m * m;
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        kept = (p >> sh) & 64'h7F_FFFF;
        re = 2 * e - 127 + (sh - 23);
`ifdef FP_SQUARE_RNE_EN
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
        if (kept == 64'h80_0000) begin
            kept = 64'd0;
            re   = re + 1;
        end
`endif
        if (re >= 255) return 32'h7F80_0000;
        if (re <= 0) return 32'h0;
        return {1'b0, re[7:0], kept[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] expv);
        int waitCnt;
        txn_t t;
        waitCnt = 0;
        @(negedge clk);
        while (!in_ready && waitCnt < 400) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("in_ready timeout", {31'b0, in_ready}, 32'h1);
            return;
        end
        in_valid = 1'b1;
        floating_point_in = x;
        @(posedge clk);
        #1;
        t.op        = x;
        t.expected  = expv;
        t.lat       = (x[30:23] == 8'hFF || x[30:23] == 8'h00) ? 1 : 26;
        t.acceptCyc = cyc;
        sbQueue.push_back(t);
        @(negedge clk);
        in_valid = 1'b0;
        floating_point_in = $urandom;
    endtask

    task automatic drain();
        int waitCnt;
        waitCnt = 0;
        while (sbQueue.size() != 0 && waitCnt < 3000) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("drain pending", sbQueue.size(), 32'h0);
    endtask

    task automatic waitOutValid();
        int waitCnt;
        waitCnt = 0;
        while (!out_valid && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("out_valid timeout", {31'b0, out_valid}, 32'h1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (readyRandom) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks the head of the scoreboard when a result appears, holds it while stalled.
    initial begin
        logic        prevValid;
        logic [31:0] held;
        txn_t        t;
        prevValid = 1'b0;
        held = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prevValid = 1'b0;
            end else begin
                if (out_valid && !prevValid) begin
                    if (sbQueue.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected out_valid actual=1 required=0");
                    end else begin
                        t = sbQueue[0];
                        checkOutput($sformatf("result of %h", t.op), result, t.expected);
                        checkOutput($sformatf("latency of %h", t.op), cyc - t.acceptCyc, t.lat);
                    end
                end else if (out_valid && prevValid) begin
                    checkOutput("held result", result, held);
                end
                if (out_valid) checkOutput("in_ready while out_valid", {31'b0, in_ready}, 32'h0);
                if (out_valid && out_ready && sbQueue.size() != 0) begin
                    void'(sbQueue.pop_front());
                    transfers++;
                end
                prevValid = out_valid;
                held = result;
            end
        end
    end

    initial begin
        logic [31:0] x;
        int r;
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset result", result, 32'h0);
        rst_n = 1'b1;

        $display("[TB] directed operands");
        applyStimulus(32'h4040_0000, 32'h4110_0000);
        applyStimulus(32'hC080_0000, 32'h4180_0000);
        applyStimulus(32'h3FC0_0000, 32'h4010_0000);
        applyStimulus(32'h7FC0_0000, 32'h7FC0_0000);
        applyStimulus(32'hFF80_0000, 32'h7F80_0000);
        applyStimulus(32'h8000_0000, 32'h0000_0000);
        applyStimulus(32'h0000_0001, 32'h0000_0000);
        applyStimulus(32'h5F80_0000, 32'h7F80_0000);
        applyStimulus(32'h1F80_0000, 32'h0000_0000);
`ifdef FP_SQUARE_RNE_EN
        applyStimulus(32'h3F80_0801, 32'h3F80_1003);
`else
        applyStimulus(32'h3F80_0801, 32'h3F80_1002);
`endif
        drain();

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        applyStimulus(32'h4180_0000, 32'h4380_0000);
        waitOutValid();
        repeat (10) @(negedge clk);
        checkOutput("stalled result", result, 32'h4380_0000);
        checkOutput("stalled in_ready", {31'b0, in_ready}, 32'h0);
        r = transfers;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("released out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("released in_ready", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        #3;
        checkOutput("single transfer", transfers - r, 32'h1);

        $display("[TB] mid-operation reset");
        applyStimulus(32'h4040_0000, 32'h4110_0000);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset mid out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset mid in_ready", {31'b0, in_ready}, 32'h1);
        sbQueue.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        applyStimulus(32'h4040_0000, 32'h4110_0000);
        drain();

        $display("[TB] randomized operands");
        readyRandom = 1'b1;
        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            r = $urandom_range(0, 9);
            case (r)
                0: x[30:23] = 8'hFF;
                1: x[30:23] = 8'h00;
                2: x[30:23] = 8'($urandom_range(185, 195));
                3: x[30:23] = 8'($urandom_range(58, 68));
                default: x[30:23] = 8'($urandom_range(1, 254));
            endcase
            applyStimulus(x, refSquare(x));
        end
        drain();
        readyRandom = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
